// File: rtl/display_scanner_if.sv
// rtl/display_scanner_if.sv - write port, display controls and scan outputs of display_scanner
// Ports (master = host/bench side, slave = display_scanner side):
//   wr_en, wr_addr, wr_data   digit register write strobe, index and 4-bit code
//   blank_mask, lz_suppress   per-digit forced blanking and leading-zero suppression enable
//   digit, an, scan_idx       current slot code, active-low anodes, current slot index
//   frame_done                one-cycle pulse on the last SHOW cycle of the last slot
interface display_scanner_if #(
    parameter int NDIGITS = 4
);
    localparam int AW = $clog2(NDIGITS);

    logic               wr_en;
    logic [AW-1:0]      wr_addr;
    logic [3:0]         wr_data;
    logic [NDIGITS-1:0] blank_mask;
    logic               lz_suppress;
    logic [3:0]         digit;
    logic [NDIGITS-1:0] an;
    logic [AW-1:0]      scan_idx;
    logic               frame_done;

    modport master (
        output wr_en, wr_addr, wr_data, blank_mask, lz_suppress,
        input  digit, an, scan_idx, frame_done
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, blank_mask, lz_suppress,
        output digit, an, scan_idx, frame_done
    );
endinterface

// File: rtl/display_scanner.sv
// rtl/display_scanner.sv - time-multiplexed scan controller for a common-anode seven-segment display
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    display_scanner_if.slave: digit write port, blanking controls, registered scan outputs
module display_scanner #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 50000,
    parameter int BLANK    = 2
) (
    input  logic              clock,
    input  logic              reset,
    display_scanner_if.slave  bus
);
    localparam int AW = $clog2(NDIGITS);
    localparam int CW = $clog2(PRESCALE);

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK - 1);
    localparam logic [CW-1:0] SHOW_LAST  = CW'(PRESCALE - BLANK - 1);
    localparam logic [AW-1:0] LAST_IDX   = AW'(NDIGITS - 1);
    localparam logic [AW:0]   NDIG_W     = (AW + 1)'(NDIGITS);

    typedef enum logic {
        ST_BLANK,
        ST_SHOW
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [AW-1:0]      idx, idx_n;
    logic [3:0]         regs [NDIGITS];

    logic [NDIGITS-1:0] suppress;
    logic               all_zero;
    logic [NDIGITS-1:0] an_n;
    logic [3:0]         digit_n;
    logic               done_n;

    // Digit registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NDIGITS; i++) begin
                regs[i] <= 4'd0;
            end
        end else if (bus.wr_en && ({1'b0, bus.wr_addr} < NDIG_W)) begin
            regs[bus.wr_addr] <= bus.wr_data;
        end
    end

    // A digit is a leading zero when it and every more significant digit are zero.
    // Walking from the top down accumulates that condition; digit 0 is never included.
    always_comb begin
        suppress = bus.blank_mask;
        all_zero = 1'b1;
        for (int i = NDIGITS - 1; i >= 1; i--) begin
            all_zero = all_zero & (regs[i] == 4'd0);
            if (bus.lz_suppress && all_zero) begin
                suppress[i] = 1'b1;
            end
        end
    end

    // State register and registered outputs
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_BLANK;
            cnt            <= '0;
            idx            <= '0;
            bus.an         <= '1;
            bus.digit      <= 4'd0;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            idx            <= idx_n;
            bus.an         <= an_n;
            bus.digit      <= digit_n;
            bus.frame_done <= done_n;
        end
    end

    assign bus.scan_idx = idx;

    // Next state, plus output values aligned to the next state so the output
    // flops line up with the slot they describe.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        case (state)
            ST_BLANK: begin
                if (cnt == BLANK_LAST) begin
                    state_n = ST_SHOW;
                    cnt_n   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt == SHOW_LAST) begin
                    state_n = ST_BLANK;
                    cnt_n   = '0;
                    idx_n   = (idx == LAST_IDX) ? '0 : idx + AW'(1);
                end
            end
            default: begin
                state_n = ST_BLANK;
                cnt_n   = '0;
            end
        endcase

        an_n = '1;
        if (state_n == ST_SHOW && !suppress[idx_n]) begin
            an_n[idx_n] = 1'b0;
        end
        digit_n = regs[idx_n];
        done_n  = (state_n == ST_SHOW) && (cnt_n == SHOW_LAST) && (idx_n == LAST_IDX);
    end
endmodule

// File: tb/tb_display_scanner.sv
// tb/tb_display_scanner.sv - directed self-checking bench for display_scanner (4-digit and 3-digit instances)
module tb_display_scanner;
    logic clock = 1'b0;
    logic reset;
    logic rst3;

    always #5 clock = ~clock;

    display_scanner_if #(.NDIGITS(4)) bus4 ();
    display_scanner_if #(.NDIGITS(3)) bus3 ();

    display_scanner #(.NDIGITS(4), .PRESCALE(8), .BLANK(2)) dut4 (
        .clock (clock),
        .reset (reset),
        .bus   (bus4.slave)
    );

    display_scanner #(.NDIGITS(3), .PRESCALE(8), .BLANK(2)) dut3 (
        .clock (clock),
        .reset (rst3),
        .bus   (bus3.slave)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int ph       = 0;
    int q        = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (ph=%0d)", tag, obs, exp, ph);
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        ph++;
        q++;
    endtask

    task automatic wr4(input logic [1:0] a, input logic [3:0] d);
        bus4.wr_en   = 1'b1;
        bus4.wr_addr = a;
        bus4.wr_data = d;
        tick();
        bus4.wr_en   = 1'b0;
    endtask

    task automatic to_phase(input int p);
        while (ph % 32 != p) tick();
    endtask

    // One full 32-cycle frame of the 4-digit instance, starting at a frame boundary.
    task automatic frame4(input string tag, input logic [3:0] lit, input logic [15:0] digs, input bit chk_dig);
        logic [3:0] exp_an;
        logic [3:0] one;
        int slot;
        int pos;
        for (int c = 0; c < 32; c++) begin
            slot   = c / 8;
            pos    = c % 8;
            one    = 4'b0001 << slot;
            exp_an = (pos >= 2 && lit[slot]) ? ~one : 4'hf;
            check($sformatf("%s_an_c%0d", tag, c), 32'(bus4.an), 32'(exp_an));
            check($sformatf("%s_fd_c%0d", tag, c), 32'(bus4.frame_done), (c == 31) ? 32'd1 : 32'd0);
            check($sformatf("%s_idx_c%0d", tag, c), 32'(bus4.scan_idx), 32'(slot));
            if (chk_dig) begin
                check($sformatf("%s_dig_c%0d", tag, c), 32'(bus4.digit), 32'(digs[slot*4 +: 4]));
            end
            tick();
        end
    endtask

    initial begin
        logic [2:0] one3;
        logic [2:0] exp3;
        int s3;

        reset = 1'b1;
        rst3  = 1'b1;
        bus4.wr_en = 1'b0; bus4.wr_addr = '0; bus4.wr_data = '0;
        bus4.blank_mask = '0; bus4.lz_suppress = 1'b0;
        bus3.wr_en = 1'b0; bus3.wr_addr = '0; bus3.wr_data = '0;
        bus3.blank_mask = '0; bus3.lz_suppress = 1'b0;
        @(negedge clock);
        @(negedge clock);

        check("rst_an",  32'(bus4.an), 32'hf);
        check("rst_dig", 32'(bus4.digit), 32'h0);
        check("rst_idx", 32'(bus4.scan_idx), 32'h0);
        check("rst_fd",  32'(bus4.frame_done), 32'h0);

        // Reset release, no writes
        reset = 1'b0;
        ph = 0;
        frame4("t1a", 4'hf, 16'h0000, 1'b1);
        frame4("t1b", 4'hf, 16'h0000, 1'b1);

        // Write 1..4 and watch them come round
        to_phase(8);
        wr4(2'd0, 4'd1);
        wr4(2'd1, 4'd2);
        wr4(2'd2, 4'd3);
        wr4(2'd3, 4'd4);
        to_phase(0);
        frame4("t2", 4'hf, 16'h4321, 1'b1);

        // Write to the digit being shown: one-cycle latency, slot timing unchanged
        to_phase(3);
        bus4.wr_en = 1'b1; bus4.wr_addr = 2'd0; bus4.wr_data = 4'd9;
        tick();
        bus4.wr_en = 1'b0;
        check("t2_live_old", 32'(bus4.digit), 32'h1);
        tick();
        check("t2_live_new", 32'(bus4.digit), 32'h9);
        check("t2_live_an",  32'(bus4.an), 32'he);

        // Leading-zero suppression
        wr4(2'd0, 4'd0);
        wr4(2'd1, 4'd5);
        wr4(2'd2, 4'd0);
        wr4(2'd3, 4'd0);
        bus4.lz_suppress = 1'b1;
        to_phase(0);
        frame4("t3", 4'b0011, 16'h0050, 1'b1);
        wr4(2'd1, 4'd0);
        to_phase(0);
        frame4("t3z", 4'b0001, 16'h0000, 1'b1);

        // Forced blanking of slot 2
        bus4.lz_suppress = 1'b0;
        bus4.blank_mask = 4'b0100;
        frame4("t4", 4'b1011, 16'h0000, 1'b1);
        bus4.blank_mask = 4'b0000;

        // Reset in the middle of slot 2's SHOW
        wr4(2'd0, 4'd3);
        wr4(2'd3, 4'd7);
        to_phase(19);
        check("t5_pre_an", 32'(bus4.an), 32'hb);
        reset = 1'b1;
        #1;
        check("t5_an",  32'(bus4.an), 32'hf);
        check("t5_dig", 32'(bus4.digit), 32'h0);
        check("t5_idx", 32'(bus4.scan_idx), 32'h0);
        check("t5_fd",  32'(bus4.frame_done), 32'h0);
        tick();
        reset = 1'b0;
        ph = 0;
        frame4("t5_after", 4'hf, 16'h0000, 1'b1);

        // Three-digit instance: out-of-range write ignored, 24-cycle frame
        rst3 = 1'b0;
        q = 0;
        for (int c = 0; c < 72; c++) begin
            if (c == 0) begin
                bus3.wr_en = 1'b1; bus3.wr_addr = 2'd3; bus3.wr_data = 4'd7;
            end else begin
                bus3.wr_en = 1'b0;
            end
            s3   = (c / 8) % 3;
            one3 = 3'b001 << s3;
            exp3 = ((c % 8) >= 2) ? ~one3 : 3'b111;
            check($sformatf("t6_an_c%0d", c),  32'(bus3.an), 32'(exp3));
            check($sformatf("t6_fd_c%0d", c),  32'(bus3.frame_done), ((c % 24) == 23) ? 32'd1 : 32'd0);
            check($sformatf("t6_idx_c%0d", c), 32'(bus3.scan_idx), 32'(s3));
            check($sformatf("t6_dig_c%0d", c), 32'(bus3.digit), 32'h0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
- Holds one 4-bit code per digit, loaded through a simple write port.
- Shares a single downstream `sevenseg` decoder across all digits by presenting one code at a time on `digit`.
- Drives the matching active-low anode enable, with a dead-time gap between slots to prevent ghosting.

Parameters:
- NDIGITS, 4: number of digits scanned; must be ≥ 2.
- PRESCALE, 50000: clock cycles per digit slot (blank plus show); must be > BLANK.
- BLANK, 2: dead-time cycles at the start of each slot with all anodes off; must be ≥ 1.

Ports:
- clock, input, 1: system clock, rising edge.
- reset, input, 1: asynchronous, active-high reset.
- wr_en, input, 1: write strobe, one write per cycle.
- wr_addr, input, $clog2(NDIGITS): digit index to write; 0 is least significant.
- wr_data, input, 4: hex code to store.
- blank_mask, input, NDIGITS: bit i = 1 keeps digit i dark.
- lz_suppress, input, 1: 1 enables leading-zero suppression.
- digit, output, 4: code for the current slot; connects to the `sevenseg` digit input.
- an, output, NDIGITS: anode enables, active low, at most one bit low.
- scan_idx, output, $clog2(NDIGITS): index of the current slot.
- frame_done, output, 1: one-cycle pulse at the end of each full scan.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous, active-high, and takes effect immediately, including mid-slot or mid-write.
- Reset values:
  - all digit registers 0
  - scan_idx = 0, FSM = BLANK, slot counter = 0
  - an = all ones, digit = 0, frame_done = 0
- Registered outputs: all outputs come from flops; there is no combinational path from inputs to outputs.
- Write port:
  - On a clock edge with wr_en = 1 and wr_addr < NDIGITS, reg[wr_addr] ← wr_data.
  - wr_addr ≥ NDIGITS is ignored (possible when NDIGITS is not a power of 2).
  - A write to the digit currently shown appears on `digit` on the edge after the write edge (1-cycle latency), without disturbing slot timing.
- FSM, states BLANK and SHOW, with one slot counter:
  - BLANK: an = all ones; `digit` = reg[scan_idx]; lasts BLANK cycles, then → SHOW.
  - SHOW: lasts PRESCALE − BLANK cycles. an[scan_idx] = 0 unless the digit is suppressed; all other bits are 1.
  - At the end of SHOW → BLANK, and scan_idx increments, wrapping from NDIGITS − 1 to 0.
- frame_done is 1 exactly during the final SHOW cycle of slot NDIGITS − 1, once every NDIGITS × PRESCALE cycles.
- Digit i is suppressed (anode held high during its SHOW) when either condition holds:
  - blank_mask[i] = 1, or
  - lz_suppress = 1, i ≠ 0, and reg[j] = 0 for all j in i..NDIGITS − 1.
- Digit 0 is never leading-zero suppressed.
- Suppression is evaluated every cycle and may change mid-slot; the anode follows one cycle later.
- A suppressed slot still occupies its full PRESCALE cycles, so the refresh rate is constant.
- Counter width is $clog2(PRESCALE). No counter overflows: the counter wraps to 0 at each state change.

Test Plan (NDIGITS = 4, PRESCALE = 8, BLANK = 2 unless stated):
1. Reset release, no writes:
   - an = 1111 ×2, 1110 ×6, 1111 ×2, 1101 ×6, … 0111 ×6, then repeats.
   - digit = 0 throughout; frame_done pulses at cycle 32 and every 32 cycles after.
2. Write 1, 2, 3, 4 to addresses 0–3:
   - digit reads 1, 2, 3, 4 in successive slots, and digit changes only in BLANK cycles.
   - A write of 9 to addr 0 during its SHOW appears on digit one cycle later.
3. Regs = {0, 0, 5, 0} (index 3..0), lz_suppress = 1:
   - digits 3 and 2 stay dark (an = 1111 in their slots); digits 1 and 0 light.
   - With all regs 0, only digit 0 lights.
4. blank_mask = 0100: slot 2 keeps an = 1111 for its full 8 cycles; the frame stays 32 cycles.
5. Assert reset in the middle of slot 2's SHOW:
   - same cycle, an = 1111, digit = 0, scan_idx = 0; regs read back as 0.
   - After release, scanning restarts at slot 0 with 2 blank cycles.
6. NDIGITS = 3, wr_addr = 3, wr_data = 7: no register changes. Scan wraps 2 → 0, and frame_done period = 24 cycles.
